opentdc_wb_master: RTL and testbench

Single-outstanding Wishbone classic initiator that drives the opentdc_wb register slave. It sits between a local command source (test sequencer or LA bridge) and the slave's wbs_* port. It converts one valid/ready command into one Wishbone cycle, bounds that cycle with a timeout, and returns the result on a valid/ready response channel.

---
 rtl/opentdc_pkg.sv | 15 +
 rtl/opentdc_wb_master.sv | 141 ++++++++++++++
 tb/tb_opentdc_wb_master.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/opentdc_pkg.sv
// Shared definitions for the opentdc Wishbone initiator: bus widths, default timeout and FSM states.
package opentdc_pkg;

    localparam int unsigned WB_ADR_W        = 32;
    localparam int unsigned WB_DAT_W        = 32;
    localparam int unsigned WB_SEL_W        = 4;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } wb_state_e;

endpackage

// File: rtl/opentdc_wb_master.sv
// Single-outstanding Wishbone classic initiator: one valid/ready command becomes one bus cycle,
// bounded by a timeout, with the result returned on a valid/ready response channel.
module opentdc_wb_master
    import opentdc_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                wb_clk_i,
    input  logic                rst_n_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [WB_ADR_W-1:0] cmd_adr_i,
    input  logic [WB_DAT_W-1:0] cmd_dat_i,
    input  logic [WB_SEL_W-1:0] cmd_sel_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [WB_DAT_W-1:0] rsp_dat_o,
    output logic                rsp_err_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [WB_DAT_W-1:0] wbm_dat_i,
    output logic                busy_o
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

    wb_state_e           state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [WB_SEL_W-1:0] sel_q, sel_d;
    logic [WB_ADR_W-1:0] adr_q, adr_d;
    logic [WB_DAT_W-1:0] dat_q, dat_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic                busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    sel_d   = cmd_sel_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    cnt_d   = '0;
                    cyc_d   = 1'b1;
                    state_d = StBus;
                end
            end
            StBus: begin
                // Ack is tested first so it wins over a timeout on the same edge.
                if (wbm_ack_i) begin
                    rsp_dat_d   = we_q ? '0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = StResp;
                end else if (cnt_q == CntLast) begin
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = StResp;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready_o = (state_q == StIdle);
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_opentdc_wb_master.sv
// Randomized bench for opentdc_wb_master with a transaction-level model and a programmable slave.
module tb_opentdc_wb_master;

    localparam int unsigned T = 8;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_we    = 1'b0;
    logic [31:0] cmd_adr   = '0;
    logic [31:0] cmd_dat   = '0;
    logic [3:0]  cmd_sel   = '0;
    logic        rsp_ready = 1'b0;
    logic        ack_force = 1'b0;

    logic        cmd_ready, rsp_valid, rsp_err, cyc, stb, we, busy, ack;
    logic [31:0] rsp_dat, adr, dat_o, wb_rdat;
    logic [3:0]  sel;

    int          slv_wait  = 0;
    int          slv_cnt   = 0;
    logic [31:0] slv_rdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    opentdc_wb_master #(.TIMEOUT(T)) dut (
        .wb_clk_i    (clk),
        .rst_n_i     (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (dat_o),
        .wbm_ack_i   (ack),
        .wbm_dat_i   (wb_rdat),
        .busy_o      (busy)
    );

    // Slave: acks after slv_wait wait states; a large slv_wait never acks.
    always @(posedge clk) begin
        if (!cyc) slv_cnt <= 0;
        else      slv_cnt <= slv_cnt + 1;
    end
    assign ack     = ack_force | (cyc && slv_cnt == slv_wait);
    assign wb_rdat = ack ? slv_rdata : 32'hdead_beef;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: a command occupies the bus for a computed number of cycles,
    // then a response is pending until the handshake.
    int          m_bus_left = 0;
    bit          m_resp     = 1'b0;
    logic        m_we       = 1'b0;
    logic        m_err      = 1'b0;
    logic [3:0]  m_sel      = '0;
    logic [31:0] m_adr      = '0;
    logic [31:0] m_dat      = '0;
    logic [31:0] m_rdat     = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_bus_left = 0;
            m_resp     = 1'b0;
        end else if (m_resp) begin
            if (rsp_ready) m_resp = 1'b0;
        end else if (m_bus_left > 0) begin
            m_bus_left--;
            if (m_bus_left == 0) m_resp = 1'b1;
        end else if (cmd_valid) begin
            m_we       = cmd_we;
            m_adr      = cmd_adr;
            m_dat      = cmd_dat;
            m_sel      = cmd_sel;
            m_err      = (slv_wait >= int'(T));
            m_bus_left = m_err ? int'(T) : slv_wait + 1;
            m_rdat     = (m_err || cmd_we) ? 32'h0 : slv_rdata;
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (rst_n) check("cmd_ready", 32'(cmd_ready), 32'(m_bus_left == 0 && !m_resp));
            check("cyc", 32'(cyc), 32'(m_bus_left > 0));
            check("stb", 32'(stb), 32'(m_bus_left > 0));
            check("busy", 32'(busy), 32'(m_bus_left > 0 || m_resp));
            check("rsp_valid", 32'(rsp_valid), 32'(m_resp));
            if (m_bus_left > 0) begin
                check("wbm_adr", adr, m_adr);
                check("wbm_dat", dat_o, m_dat);
                check("wbm_we", 32'(we), 32'(m_we));
                check("wbm_sel", 32'(sel), 32'(m_sel));
            end
            if (m_resp) begin
                check("rsp_dat", rsp_dat, m_rdat);
                check("rsp_err", 32'(rsp_err), 32'(m_err));
            end
        end
    end

    task automatic txn(input logic we_i, input logic [31:0] adr_i, input logic [31:0] dat_i,
                       input logic [3:0] sel_i, input int wt, input logic [31:0] rdat,
                       input int hold);
        int          n;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] exp_rd;
        exp_err = (wt >= int'(T));
        exp_cyc = exp_err ? int'(T) : wt + 1;
        exp_rd  = (exp_err || we_i) ? 32'h0 : rdat;
        @(negedge clk);
        slv_wait  = wt;
        slv_rdata = rdat;
        cmd_we    = we_i;
        cmd_adr   = adr_i;
        cmd_dat   = dat_i;
        cmd_sel   = sel_i;
        cmd_valid = 1'b1;
        n = 0;
        while (!cyc && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept", 32'(cyc), 32'd1);
        if (!cyc) begin
            cmd_valid = 1'b0;
            return;
        end
        if (hold == 0) cmd_valid = 1'b0;
        n = 0;
        while (cyc && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("cyc_len", 32'(n), 32'(exp_cyc));
        check("rsp_valid_at_drop", 32'(rsp_valid), 32'd1);
        check("txn_err", 32'(rsp_err), 32'(exp_err));
        check("txn_dat", rsp_dat, exp_rd);
        for (int i = 0; i < hold; i++) begin
            ack_force = (i == 2);
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_dat", rsp_dat, exp_rd);
            check("hold_err", 32'(rsp_err), 32'(exp_err));
            check("hold_ready", 32'(cmd_ready), 32'd0);
            check("hold_cyc", 32'(cyc), 32'd0);
        end
        ack_force = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_cyc", 32'(cyc), 32'd0);
        check("rst_stb", 32'(stb), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_adr", adr, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_dat", rsp_dat, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        txn(1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF, 0, 32'h0, 0);
        txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 3, 32'hCAFE_F00D, 0);
        txn(1'b1, 32'h3000_0010, 32'h5555_AAAA, 4'h3, 1000, 32'h0, 0);
        txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 0, 32'h0000_55AA, 0);
        txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, int'(T) - 1, 32'hA5A5_1234, 0);
        txn(1'b0, 32'h3000_0014, 32'h0, 4'hF, 2, 32'h0BAD_CAFE, 5);

        // Reset in the middle of a bus cycle.
        @(negedge clk);
        slv_wait  = 1000;
        cmd_we    = 1'b0;
        cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        check("pre_rst_cyc", 32'(cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_cyc", 32'(cyc), 32'd0);
        check("async_stb", 32'(stb), 32'd0);
        check("async_valid", 32'(rsp_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_mid_rst", 32'(cmd_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        end

        repeat (150) begin
            txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 10)), $urandom, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
